// File: rtl/hv_bind_bundle_encoder.sv
// hv_bind_bundle_encoder
// Binds two item-memory hypervectors by XOR and bundles the bound vectors of a
// sequence into per-bit saturating counters. On the last beat the majority
// (counter > 0) vector and the beat count are held for a valid/ready consumer.
// Optional feature macro: HV_ENCODER_PERMUTE_EN rotates each bound vector
// left by its beat index before accumulation, for sequence/n-gram encoding.
module hv_bind_bundle_encoder #(
  parameter int unsigned HVDimension   = 512,
  parameter int unsigned NumImElements = 1024,
  parameter int unsigned CounterWidth  = 8,
  parameter int unsigned BeatCntWidth  = 16,
  localparam int unsigned ImSelWidth   = $clog2(NumImElements)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic [ImSelWidth-1:0]   in_sel_a_i,
  input  logic [ImSelWidth-1:0]   in_sel_b_i,
  input  logic                    in_last_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [ImSelWidth-1:0]   im_sel_a_o,
  output logic [ImSelWidth-1:0]   im_sel_b_o,
  input  logic [HVDimension-1:0]  im_a_i,
  input  logic [HVDimension-1:0]  im_b_i,
  output logic [HVDimension-1:0]  out_hv_o,
  output logic [BeatCntWidth-1:0] out_count_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [CounterWidth-1:0] CntMax = {1'b0, {(CounterWidth-1){1'b1}}};
  localparam logic [CounterWidth-1:0] CntMin = {1'b1, {(CounterWidth-1){1'b0}}};
  localparam logic [CounterWidth-1:0] CntOne = {{(CounterWidth-1){1'b0}}, 1'b1};
  localparam logic [BeatCntWidth-1:0] BeatOne = {{(BeatCntWidth-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [HVDimension-1:0]  out_hv_q, out_hv_d;
  logic [BeatCntWidth-1:0] out_count_q, out_count_d;
  logic [BeatCntWidth-1:0] beat_cnt_q, beat_cnt_d, beat_cnt_upd;

  logic                    accept;
  logic                    clear;
  logic [HVDimension-1:0]  bound;
  logic [HVDimension-1:0]  contrib;
  logic [HVDimension-1:0]  maj_bits;

  // Item memory selects are a pure pass-through so the lookup fits in one cycle.
  assign im_sel_a_o = in_sel_a_i;
  assign im_sel_b_o = in_sel_b_i;

  assign in_ready_o  = (state_q == ACCUM) && !clr_i;
  assign accept      = in_valid_i && in_ready_o;
  // Accumulation restarts on an explicit clear or once the result is taken.
  assign clear       = clr_i || ((state_q == HOLD) && out_ready_i);
  assign bound       = im_a_i ^ im_b_i;

`ifdef HV_ENCODER_PERMUTE_EN
  logic [BeatCntWidth-1:0] rot_amt;
  // The pre-increment beat count selects the rotation, so beat 0 is unrotated.
  assign rot_amt = beat_cnt_q % BeatCntWidth'(HVDimension);
  // Shifting by the full width yields zero, which keeps rot_amt == 0 correct.
  assign contrib = (bound << rot_amt) | (bound >> (BeatCntWidth'(HVDimension) - rot_amt));
`else
  assign contrib = bound;
`endif

  // Saturating beat counter; its post-update value is what gets reported.
  always_comb begin
    beat_cnt_upd = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + BeatOne;
    beat_cnt_d   = beat_cnt_q;
    if (clear) begin
      beat_cnt_d = '0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_upd;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  for (genvar gi = 0; gi < HVDimension; gi++) begin : g_bit
    logic [CounterWidth-1:0] cnt_q, cnt_d, cnt_upd;

    // Two's-complement up/down counter that sticks at its extremes.
    always_comb begin
      if (contrib[gi]) begin
        cnt_upd = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
      end else begin
        cnt_upd = (cnt_q == CntMin) ? cnt_q : cnt_q - CntOne;
      end
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (accept) begin
        cnt_d = cnt_upd;
      end
    end

    // Majority bit: strictly positive; a tie at zero binarizes to 0.
    assign maj_bits[gi] = ~cnt_upd[CounterWidth-1] & (|cnt_upd);

    // Per-bit bundling counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Next-state and output logic; clear beats handshake, handshake beats input.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_hv_d    = out_hv_q;
    out_count_d = out_count_q;
    if (clr_i) begin
      state_d     = ACCUM;
      out_valid_d = 1'b0;
    end else if ((state_q == HOLD) && out_ready_i) begin
      state_d     = ACCUM;
      out_valid_d = 1'b0;
    end else if (accept && in_last_i) begin
      state_d     = HOLD;
      out_valid_d = 1'b1;
      out_hv_d    = maj_bits;
      out_count_d = beat_cnt_upd;
    end
  end

  // FSM state with registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACCUM;
      out_valid_q <= 1'b0;
      out_hv_q    <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_hv_q    <= out_hv_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_hv_o    = out_hv_q;
  assign out_count_o = out_count_q;

endmodule
